// File: rtl/relm_div_pkg.sv
// Shared types and constants for the relm_div_seq restoring divider.
// Default geometry is 32-bit operands retiring 2 quotient bits per cycle.
package relm_div_pkg;

  localparam int DIV_WD   = 32;
  localparam int DIV_RB   = 2;
  localparam int DIV_ITER = DIV_WD / DIV_RB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_DZ   = 2'd1,
    SP_OVF  = 2'd2,
    SP_ZERO = 2'd3
  } special_e;

  function automatic int div_cnt_width(input int iter);
    return (iter > 1) ? $clog2(iter) : 1;
  endfunction

  localparam int DIV_CW = div_cnt_width(DIV_ITER);

  // Divide-by-zero wins over overflow; the zero-dividend shortcut only exists with early exit.
  function automatic special_e div_special(input logic d_zero, input logic sgn,
                                           input logic n_min, input logic d_ones,
                                           input logic n_zero, input logic early);
    if (d_zero) return SP_DZ;
    if (sgn && n_min && d_ones) return SP_OVF;
    if (early && n_zero) return SP_ZERO;
    return SP_NONE;
  endfunction

endpackage

// File: rtl/relm_div_step.sv
// One restoring division step: shift in the next dividend bit, compare, subtract, emit a quotient bit.
// Purely combinational; the dividend register doubles as the quotient collector.
module relm_div_step #(
  parameter int WD = 32
) (
  input  logic [WD-1:0] r_i,
  input  logic [WD-1:0] n_i,
  input  logic [WD-1:0] d_i,
  output logic [WD-1:0] r_o,
  output logic [WD-1:0] n_o
);

  logic [WD:0] r_sh;
  logic        ge;

  assign r_sh = {r_i, n_i[WD-1]};
  assign ge   = (r_sh >= {1'b0, d_i});
  // The difference is below D, so the low WD bits of a modular subtract are exact.
  assign r_o  = ge ? (r_sh[WD-1:0] - d_i) : r_sh[WD-1:0];
  assign n_o  = {n_i[WD-2:0], ge};

endmodule

// File: rtl/relm_div_seq.sv
// Self-timed signed/unsigned divider, RB quotient bits per cycle, valid/ready on both sides; results held until out_ready.
// Define RELM_DIV_EARLY_EXIT_EN to skip leading zero groups of |N| (latency max(1, ITER-lz)); results are identical.
module relm_div_seq
  import relm_div_pkg::*;
#(
  parameter int WD = DIV_WD,
  parameter int RB = DIV_RB
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_signed,
  input  logic [WD-1:0] in_n,
  input  logic [WD-1:0] in_d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WD-1:0] out_q,
  output logic [WD-1:0] out_r,
  output logic          out_dz,
  output logic          busy
);

  localparam int ITER = WD / RB;
  localparam int CW   = div_cnt_width(ITER);

`ifdef RELM_DIV_EARLY_EXIT_EN
  localparam logic EARLY = 1'b1;
`else
  localparam logic EARLY = 1'b0;
`endif

  state_e        state_q;
  logic [WD-1:0] rem_q, num_q, den_q, quo_q, res_r_q;
  logic [CW-1:0] cnt_q;
  logic          qneg_q, rneg_q, dz_q;

  logic          n_neg_d, d_neg_d;
  logic [WD-1:0] n_mag_d, d_mag_d, n_load_d;
  logic [CW-1:0] cnt_load_d;
  special_e      special_d;
  logic [WD-1:0] quo_fix_d, rem_fix_d;

  assign n_neg_d   = in_signed & in_n[WD-1];
  assign d_neg_d   = in_signed & in_d[WD-1];
  assign n_mag_d   = n_neg_d ? (~in_n + 1'b1) : in_n;
  assign d_mag_d   = d_neg_d ? (~in_d + 1'b1) : in_d;
  assign special_d = div_special(in_d == '0, in_signed, in_n == {1'b1, {(WD-1){1'b0}}},
                                 &in_d, in_n == '0, EARLY);

`ifdef RELM_DIV_EARLY_EXIT_EN
  logic [CW-1:0] lz_d;
  logic          lz_done;

  // Group 0 is never skipped, so lz tops out at ITER-1 and at least one RUN cycle remains.
  always_comb begin
    lz_d    = '0;
    lz_done = 1'b0;
    for (int g = ITER - 1; g >= 1; g--) begin
      if (!lz_done && (n_mag_d[g*RB +: RB] == '0)) lz_d = lz_d + CW'(1);
      else lz_done = 1'b1;
    end
  end

  assign n_load_d   = n_mag_d << (lz_d * RB);
  assign cnt_load_d = CW'(ITER - 1) - lz_d;
`else
  assign n_load_d   = n_mag_d;
  assign cnt_load_d = CW'(ITER - 1);
`endif

  logic [WD-1:0] r_ch [RB+1];
  logic [WD-1:0] n_ch [RB+1];

  assign r_ch[0] = rem_q;
  assign n_ch[0] = num_q;

  for (genvar s = 0; s < RB; s++) begin : g_step
    relm_div_step #(.WD(WD)) u_step (
      .r_i (r_ch[s]),
      .n_i (n_ch[s]),
      .d_i (den_q),
      .r_o (r_ch[s+1]),
      .n_o (n_ch[s+1])
    );
  end

  assign quo_fix_d = qneg_q ? (~n_ch[RB] + 1'b1) : n_ch[RB];
  assign rem_fix_d = rneg_q ? (~r_ch[RB] + 1'b1) : r_ch[RB];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      num_q   <= '0;
      den_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quo_q   <= '0;
      res_r_q <= '0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            qneg_q <= n_neg_d ^ d_neg_d;
            rneg_q <= n_neg_d;
            case (special_d)
              SP_DZ: begin
                quo_q   <= '1;
                res_r_q <= in_n;
                dz_q    <= 1'b1;
                state_q <= DONE;
              end
              SP_OVF: begin
                quo_q   <= {1'b1, {(WD-1){1'b0}}};
                res_r_q <= '0;
                dz_q    <= 1'b0;
                state_q <= DONE;
              end
              SP_ZERO: begin
                quo_q   <= '0;
                res_r_q <= '0;
                dz_q    <= 1'b0;
                state_q <= DONE;
              end
              default: begin
                rem_q   <= '0;
                num_q   <= n_load_d;
                den_q   <= d_mag_d;
                cnt_q   <= cnt_load_d;
                state_q <= RUN;
              end
            endcase
          end
        end
        RUN: begin
          rem_q <= r_ch[RB];
          num_q <= n_ch[RB];
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            quo_q   <= quo_fix_d;
            res_r_q <= rem_fix_d;
            dz_q    <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_q     = quo_q;
  assign out_r     = res_r_q;
  assign out_dz    = dz_q;

endmodule

// File: tb/tb_relm_div_seq.sv
// Directed bench for relm_div_seq (WD=32, RB=2): vector table plus backpressure, reset and back-to-back sequences.
module tb_relm_div_seq;

  localparam int WD = 32;
  localparam int RB = 2;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_signed, out_valid, out_ready, out_dz, busy;
  logic [WD-1:0] in_n, in_d, out_q, out_r;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  relm_div_seq #(.WD(WD), .RB(RB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_n      (in_n),
    .in_d      (in_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .out_dz    (out_dz),
    .busy      (busy)
  );

  // lat_* = clock edges after the accept edge until out_valid is seen high
  typedef struct {
    logic        sgn;
    logic [31:0] n;
    logic [31:0] d;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat_def;
    int          lat_ee;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic accept(input logic sgn, input logic [31:0] n, input logic [31:0] d);
    in_signed = sgn;
    in_n      = n;
    in_d      = d;
    in_valid  = 1'b1;
    chk("accept_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL wait_valid: out_valid still %b after %0d cycles, expected 1", out_valid, lat);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int exp_lat;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    in_n      = '0;
    in_d      = '0;
    out_ready = 1'b0;

    //            sgn   N             D             Q             R             dz  def ee
    vecs[0]  = '{1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 16, 4};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 16, 2};
    vecs[2]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 16, 2};
    vecs[3]  = '{1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 0,  0};
    vecs[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 0,  0};
    vecs[5]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 16, 16};
    vecs[6]  = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 16, 4};
    vecs[7]  = '{1'b1, 32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 16, 0};
    vecs[8]  = '{1'b1, 32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0, 16, 16};
    vecs[9]  = '{1'b0, 32'd7,        32'd9,        32'd0,        32'd7,        1'b0, 16, 2};
    vecs[10] = '{1'b1, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 0,  0};
    vecs[11] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 16, 16};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_out_q",     out_q,              32'd0);
    chk("rst_out_r",     out_r,              32'd0);
    chk("rst_out_dz",    {31'd0, out_dz},    32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
`ifdef RELM_DIV_EARLY_EXIT_EN
      exp_lat = vecs[i].lat_ee;
`else
      exp_lat = vecs[i].lat_def;
`endif
      accept(vecs[i].sgn, vecs[i].n, vecs[i].d);
      wait_valid(lat);
      chk($sformatf("vec%0d_q", i),   out_q,               vecs[i].q);
      chk($sformatf("vec%0d_r", i),   out_r,               vecs[i].r);
      chk($sformatf("vec%0d_dz", i),  {31'd0, out_dz},     {31'd0, vecs[i].dz});
      chk($sformatf("vec%0d_lat", i), lat,                 exp_lat);
      handshake();
      chk($sformatf("vec%0d_rdy_after", i), {31'd0, in_ready}, 32'd1);
    end

    // Backpressure: result must hold while out_ready is low; new requests are dropped.
    accept(1'b0, 32'hFFFFFFFF, 32'd3);
    wait_valid(lat);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_n     = 32'd9;
      in_d     = 32'd3;
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_q", c),     out_q,                32'h55555555);
      chk($sformatf("bp%0d_r", c),     out_r,                32'd0);
      chk($sformatf("bp%0d_valid", c), {31'd0, out_valid},   32'd1);
      chk($sformatf("bp%0d_rdy", c),   {31'd0, in_ready},    32'd0);
    end
    in_valid = 1'b0;
    handshake();
    chk("bp_rdy_after",   {31'd0, in_ready},  32'd1);
    chk("bp_valid_after", {31'd0, out_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_not_queued", {31'd0, busy}, 32'd0);

    // Reset in the 8th RUN cycle discards the operation.
    accept(1'b0, 32'hFFFFFFFF, 32'd3);
    repeat (7) @(posedge clk);
    #1;
    chk("mid_run_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstrun_valid", {31'd0, out_valid}, 32'd0);
    chk("rstrun_rdy",   {31'd0, in_ready},  32'd1);
    chk("rstrun_busy",  {31'd0, busy},      32'd0);
    accept(1'b0, 32'd9, 32'd3);
    wait_valid(lat);
    chk("post_rst_q", out_q, 32'd3);
    chk("post_rst_r", out_r, 32'd0);
`ifdef RELM_DIV_EARLY_EXIT_EN
    chk("post_rst_lat", lat, 32'd2);
`else
    chk("post_rst_lat", lat, 32'd16);
`endif
    handshake();

    // Back-to-back with out_ready tied high; the second request waits in in_valid.
    out_ready = 1'b1;
    in_signed = 1'b0;
    in_n      = 32'd1000;
    in_d      = 32'd10;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_n = 32'h12345678;
    in_d = 32'h100;
    wait_valid(lat);
    chk("b2b1_q", out_q, 32'd100);
    chk("b2b1_r", out_r, 32'd0);
    @(posedge clk);
    #1;
    chk("b2b_idle_rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("b2b2_accepted", {31'd0, busy}, 32'd1);
    wait_valid(lat);
    chk("b2b2_q", out_q, 32'h00123456);
    chk("b2b2_r", out_r, 32'h78);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("b2b_final_rdy", {31'd0, in_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
